// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs feeding a single registered broadcast port.
// Round-robin pick among non-empty FIFOs, one broadcast per cycle, no backpressure from the ROB.

module cdb_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 39
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic                   o_ready,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // Readiness is taken from the pre-edge count, so a pop never frees a slot for the same edge.
    assign o_ready = (r_count < (PW+1)'(DEPTH)) && !i_flush;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = i_pop && (r_count != '0) && !i_flush;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module cdb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic [NUM_UNITS-1:0]                        eu_valid,
    output logic [NUM_UNITS-1:0]                        eu_ready,
    input  logic [NUM_UNITS*TAG_WIDTH-1:0]              eu_tag,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]             eu_data,
    input  logic [NUM_UNITS-1:0]                        eu_exception,
    output logic                                        cdb_valid,
    output logic [TAG_WIDTH-1:0]                        cdb_tag,
    output logic [DATA_WIDTH-1:0]                       cdb_data,
    output logic                                        cdb_exception,
    output logic [NUM_UNITS-1:0]                        cdb_grant,
    output logic [NUM_UNITS*($clog2(FIFO_DEPTH)+1)-1:0] fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int UW = $clog2(NUM_UNITS);
    localparam int EW = 1 + TAG_WIDTH + DATA_WIDTH;

    logic [NUM_UNITS-1:0][EW-1:0] w_heads;
    logic [NUM_UNITS-1:0][CW-1:0] w_counts;
    logic [NUM_UNITS-1:0]         w_nonempty;
    logic [NUM_UNITS-1:0]         w_pop;
    logic                         w_found;
    logic [UW-1:0]                w_winner;
    logic [UW-1:0]                w_rr_next;
    logic [EW-1:0]                w_win_entry;

    logic [UW-1:0]         r_rr_ptr;
    logic                  r_valid;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_exc;
    logic [NUM_UNITS-1:0]  r_grant;

    genvar g;
    generate
        for (g = 0; g < NUM_UNITS; g++) begin : g_unit
            cdb_unit_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (flush),
                .i_valid (eu_valid[g]),
                .i_data  ({eu_exception[g], eu_tag[g*TAG_WIDTH +: TAG_WIDTH],
                           eu_data[g*DATA_WIDTH +: DATA_WIDTH]}),
                .i_pop   (w_pop[g]),
                .o_ready (eu_ready[g]),
                .o_head  (w_heads[g]),
                .o_count (w_counts[g])
            );
            assign w_nonempty[g]          = (w_counts[g] != '0);
            assign w_pop[g]               = w_found && (w_winner == UW'(g));
            assign fifo_count[g*CW +: CW] = w_counts[g];
        end
    endgenerate

    // First non-empty unit scanning upward from r_rr_ptr, wrapping at NUM_UNITS.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_UNITS;
            if (!w_found && w_nonempty[idx]) begin
                w_found  = 1'b1;
                w_winner = UW'(idx);
            end
        end
    end

    assign w_rr_next   = (w_winner == UW'(NUM_UNITS - 1)) ? '0 : w_winner + UW'(1);
    assign w_win_entry = w_heads[w_winner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_valid  <= 1'b0;
            r_tag    <= '0;
            r_data   <= '0;
            r_exc    <= 1'b0;
            r_grant  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_grant <= '0;
        end else if (w_found) begin
            r_valid  <= 1'b1;
            r_exc    <= w_win_entry[EW-1];
            r_tag    <= w_win_entry[DATA_WIDTH +: TAG_WIDTH];
            r_data   <= w_win_entry[DATA_WIDTH-1:0];
            r_grant  <= NUM_UNITS'(1) << w_winner;
            r_rr_ptr <= w_rr_next;
        end else begin
            r_valid <= 1'b0;
            r_grant <= '0;
        end
    end

    assign cdb_valid     = r_valid;
    assign cdb_tag       = r_tag;
    assign cdb_data      = r_data;
    assign cdb_exception = r_exc;
    assign cdb_grant     = r_grant;
endmodule
